// File: rtl/spi_seq_pkg.sv
// Shared types and default constants for the SPI transaction sequencer and its command FIFO.
// Commands are packed as {rw, addr, saddr, raddr}.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

    localparam int SEQ_DEPTH        = 4;
    localparam int SEQ_AW           = 3;
    localparam int SEQ_MAX_ADDR     = 4;
    localparam int SEQ_FRAME_CYCLES = 21;
    localparam int SEQ_GAP_CYCLES   = 2;

    function automatic int cmd_width(input int aw);
        return 1 + 3 * aw;
    endfunction

    // Counter only has to reach the longer of the two phase lengths.
    function automatic int cnt_width(input int frame_cycles, input int gap_cycles);
        int longest;
        longest = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is presented combinationally.
// Pushes while full and pops while empty are ignored.
module spi_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                     sclk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queues SPI transaction commands and frames each one: ss low for FRAME_CYCLES, then high for
// GAP_CYCLES with rw/addr/saddr/raddr held stable; out-of-range commands are dropped with err.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH        = SEQ_DEPTH,
    parameter int AW           = SEQ_AW,
    parameter int MAX_ADDR     = SEQ_MAX_ADDR,
    parameter int FRAME_CYCLES = SEQ_FRAME_CYCLES,
    parameter int GAP_CYCLES   = SEQ_GAP_CYCLES
) (
    input  logic                   sclk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [AW-1:0]          cmd_saddr,
    input  logic [AW-1:0]          cmd_raddr,
    output logic                   ss,
    output logic                   rw,
    output logic [AW-1:0]          addr,
    output logic [AW-1:0]          saddr,
    output logic [AW-1:0]          raddr,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW    = cmd_width(AW);
    localparam int CNT_W = cnt_width(FRAME_CYCLES, GAP_CYCLES);
    localparam logic [AW-1:0]    MAX_A      = AW'(MAX_ADDR);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             handshake;
    logic             addr_bad;
    logic             push;
    logic             pop;
    logic             done_set;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    head;

    // A rejected command still completes its handshake; it simply never reaches the FIFO.
    assign handshake = cmd_valid & cmd_ready;
    assign addr_bad  = (cmd_addr > MAX_A) | (cmd_saddr > MAX_A) | (cmd_raddr > MAX_A);
    assign push      = handshake & ~addr_bad;
    assign cmd_ready = ~fifo_full;

    spi_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({cmd_rw, cmd_addr, cmd_saddr, cmd_raddr}),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter is cleared on every phase change, so it never wraps.
    always_comb begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (cnt == FRAME_LAST) begin
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_FRAME;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt != GAP_LAST) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ss and busy decode straight from state so reset raises ss without waiting for a clock.
    always_comb begin
        ss       = 1'b1;
        busy     = 1'b0;
        pop      = 1'b0;
        done_set = 1'b0;
        case (state)
            ST_IDLE: begin
                pop = ~fifo_empty;
            end
            ST_FRAME: begin
                ss       = 1'b0;
                busy     = 1'b1;
                done_set = (cnt == FRAME_LAST);
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                ss = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= done_set;
            err  <= handshake & addr_bad;
        end
    end

    // Transaction fields only move on a pop and otherwise hold through frame, gap and idle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rw    <= 1'b0;
            addr  <= '0;
            saddr <= '0;
            raddr <= '0;
        end else if (pop) begin
            {rw, addr, saddr, raddr} <= head;
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: framing, queueing order, rejection, full-FIFO
// behaviour and asynchronous reset mid-frame.
module tb_spi_txn_sequencer;

    logic       sclk      = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic [2:0] cmd_addr  = 3'd0;
    logic [2:0] cmd_saddr = 3'd0;
    logic [2:0] cmd_raddr = 3'd0;
    logic       cmd_ready;
    logic       ss;
    logic       rw;
    logic [2:0] addr;
    logic [2:0] saddr;
    logic [2:0] raddr;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 sclk = ~sclk;

    spi_txn_sequencer dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_addr   (cmd_addr),
        .cmd_saddr  (cmd_saddr),
        .cmd_raddr  (cmd_raddr),
        .ss         (ss),
        .rw         (rw),
        .addr       (addr),
        .saddr      (saddr),
        .raddr      (raddr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic r, input logic [2:0] a, input logic [2:0] s,
                        input logic [2:0] d, output int w);
        w = 0;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_saddr = s;
        cmd_raddr = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 400) begin
            @(negedge sclk);
            w++;
        end
        chk("send_ready", cmd_ready, 1);
        @(negedge sclk);
        cmd_valid = 1'b0;
    endtask

    // Starts on a sample with ss low; measures low length, following high length,
    // done pulses seen and how many high samples elapse before busy drops.
    task automatic frame_watch(output int lo, output int hi, output int dn, output int gp);
        lo = 0;
        hi = 0;
        dn = 0;
        gp = -1;
        while (!ss && lo < 100) begin
            lo++;
            @(negedge sclk);
            dn += int'(done);
        end
        while (ss && hi < 60) begin
            if (!busy && gp < 0) gp = hi;
            hi++;
            @(negedge sclk);
            dn += int'(done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lo, hi, dn, gp, w;
        logic [2:0] ea [6];
        logic       er [6];

        repeat (3) @(negedge sclk);
        chk("rst_ss", ss, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_addr", {rw, addr, saddr, raddr}, 0);
        rst_n = 1'b1;
        @(negedge sclk);

        // Single transaction: latency, framing and busy tail
        send(1'b1, 3'd2, 3'd3, 3'd1, w);
        chk("t1_count_pushed", fifo_count, 1);
        chk("t1_ss_latency", ss, 1);
        @(negedge sclk);
        chk("t1_ss_low", ss, 0);
        chk("t1_rw", rw, 1);
        chk("t1_addr", addr, 2);
        chk("t1_saddr", saddr, 3);
        chk("t1_raddr", raddr, 1);
        chk("t1_busy", busy, 1);
        chk("t1_count_popped", fifo_count, 0);
        frame_watch(lo, hi, dn, gp);
        chk("t1_low_len", lo, 21);
        chk("t1_done_cnt", dn, 1);
        chk("t1_busy_tail", gp, 2);
        chk("t1_idle_ss", ss, 1);
        chk("t1_hold_addr", addr, 2);

        // Out-of-range commands are consumed, flagged and dropped
        send(1'b0, 3'd5, 3'd0, 3'd0, w);
        chk("t3_err_addr", err, 1);
        chk("t3_count_addr", fifo_count, 0);
        @(negedge sclk);
        chk("t3_err_clear", err, 0);
        send(1'b0, 3'd0, 3'd7, 3'd0, w);
        chk("t3_err_saddr", err, 1);
        chk("t3_count_saddr", fifo_count, 0);
        send(1'b1, 3'd0, 3'd0, 3'd6, w);
        chk("t3_err_raddr", err, 1);
        chk("t3_count_raddr", fifo_count, 0);
        @(negedge sclk);
        chk("t3_no_frame_ss", ss, 1);
        chk("t3_no_frame_busy", busy, 0);
        chk("t3_hold_addr", addr, 2);

        // Back-to-back queueing, full FIFO and ordered frames
        for (int k = 0; k < 6; k++) begin
            ea[k] = 3'(k % 5);
            er[k] = k[0];
        end
        for (int k = 0; k < 5; k++) begin
            send(er[k], ea[k], 3'(4 - k), 3'((k + 1) % 5), w);
        end
        chk("t2_count_full", fifo_count, 4);
        chk("t2_ready_low", cmd_ready, 0);
        chk("t2_first_addr", addr, ea[0]);
        chk("t2_first_ss", ss, 0);
        send(er[5], ea[5], 3'd4, 3'd0, w);
        chk("t4_wait_cycles", w, 21);
        chk("t4_count_refill", fifo_count, 4);
        for (int k = 1; k < 6; k++) begin
            chk("t2_order_addr", addr, ea[k]);
            chk("t2_order_rw", rw, er[k]);
            frame_watch(lo, hi, dn, gp);
            chk("t2_low_len", lo, (k == 1) ? 20 : 21);
            if (k < 5) chk("t2_gap_high", hi, 3);
            chk("t2_done_cnt", dn, 1);
            chk("t2_busy_tail", gp, 2);
        end
        chk("t2_count_end", fifo_count, 0);

        // Asynchronous reset in the middle of a frame
        send(1'b1, 3'd1, 3'd1, 3'd1, w);
        @(negedge sclk);
        chk("t5_ss_low", ss, 0);
        send(1'b0, 3'd2, 3'd2, 3'd2, w);
        chk("t5_count_queued", fifo_count, 1);
        repeat (9) @(negedge sclk);
        rst_n = 1'b0;
        #1;
        chk("t5_ss_async", ss, 1);
        chk("t5_count_flush", fifo_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_fields", {rw, addr, saddr, raddr}, 0);
        chk("t5_done", done, 0);
        @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        chk("t5_ss_after", ss, 1);
        chk("t5_done_after", done, 0);
        chk("t5_count_after", fifo_count, 0);
        send(1'b0, 3'd3, 3'd4, 3'd2, w);
        @(negedge sclk);
        chk("t5_new_ss", ss, 0);
        chk("t5_new_addr", addr, 3);
        frame_watch(lo, hi, dn, gp);
        chk("t5_new_low_len", lo, 21);
        chk("t5_new_done", dn, 1);

        // Framing for an end-to-end style transfer
        send(1'b1, 3'd0, 3'd2, 3'd3, w);
        @(negedge sclk);
        chk("t6_fields", {rw, addr, saddr, raddr}, {1'b1, 3'd0, 3'd2, 3'd3});
        chk("t6_ss", ss, 0);
        frame_watch(lo, hi, dn, gp);
        chk("t6_low_len", lo, 21);
        chk("t6_done", dn, 1);
        chk("t6_hold", {rw, addr, saddr, raddr}, {1'b1, 3'd0, 3'd2, 3'd3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
